// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Sits in front of the RV32IM single-cycle core. It takes a program image as a
// byte stream (valid/ready handshake), builds little-endian 32-bit instruction
// words, and writes them one after another into the instruction memory write
// port. It also keeps a running XOR checksum. The core stays in reset, with PC
// updates blocked, until a load finishes with a matching checksum. After that
// the core is released and starts executing from PC 0.
//
// Stream layout: N (16-bit, low byte first), N*4 data bytes (each word low
// byte first), then one checksum byte. The checksum byte is the XOR of every
// byte before it, header included.
//
// Ports:
//   CPU_clk        system clock, rising edge
//   CPU_rst        asynchronous active-high reset
//   Ld_Byte_Valid  source presents a byte
//   Ld_Byte        stream byte
//   Ld_Byte_Ready  loader accepts a byte this cycle (transfer = Valid & Ready)
//   IMEM_WrEn      one-cycle IMEM write strobe
//   IMEM_WrAddr    IMEM word address
//   IMEM_WrData    assembled instruction word
//   Core_rst_n     active-low reset into the core
//   CPU_PCWrite    PC write enable into the core
//   Ld_Done        load completed cleanly (sticky until reset)
//   Ld_Error       load failed (sticky until reset)
//   Ld_WordCount   word count N taken from the header
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   CPU_clk,
  input  logic                   CPU_rst,
  input  logic                   Ld_Byte_Valid,
  input  logic [7:0]             Ld_Byte,
  output logic                   Ld_Byte_Ready,
  output logic                   IMEM_WrEn,
  output logic [ADDR_WIDTH-1:0]  IMEM_WrAddr,
  output logic [INSTR_WIDTH-1:0] IMEM_WrData,
  output logic                   Core_rst_n,
  output logic                   CPU_PCWrite,
  output logic                   Ld_Done,
  output logic                   Ld_Error,
  output logic [15:0]            Ld_WordCount
);

  typedef enum logic [3:0] {
    ST_INIT,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_CHECK,
    ST_DATA,
    ST_CSUM,
    ST_RELEASE,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(IMEM_DEPTH);

  state_t                state;
  logic [7:0]            hdr_lo;
  logic [7:0]            csum;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [23:0]           word_buf;
  logic                  xfer;
  logic [15:0]           last_word;
  logic                  last_hit;

  // A byte moves only when the source offers it and we are ready. Ready is a
  // register, so bytes offered while Ready is low are simply never taken.
  assign xfer = Ld_Byte_Valid & Ld_Byte_Ready;

  // Ld_WordCount holds N once the header has been read. It is only used for
  // this comparison while in DATA, where 1 <= N <= IMEM_DEPTH, so N-1 never
  // underflows.
  assign last_word = Ld_WordCount - 16'd1;
  assign last_hit  = ({{(16 - ADDR_WIDTH){1'b0}}, word_idx} == last_word);

  // The whole loader lives in one registered process: the state, the
  // handshake ready, the write port and the core-control outputs.
  // Core-control and status outputs are a registered decode of the current
  // state, so they lag the state by one edge. This gives Ld_Error one edge
  // after the failing CHECK/CSUM edge. It also gives Ld_Done/Core_rst_n two
  // edges after the good checksum edge, because RELEASE sits in between.
  // Ready, by contrast, is set and cleared directly on the transition edges,
  // so the handshake never loses a cycle.
  always_ff @(posedge CPU_clk or posedge CPU_rst) begin
    if (CPU_rst) begin
      state         <= ST_INIT;
      Ld_Byte_Ready <= 1'b0;
      IMEM_WrEn     <= 1'b0;
      IMEM_WrAddr   <= '0;
      IMEM_WrData   <= '0;
      Core_rst_n    <= 1'b0;
      CPU_PCWrite   <= 1'b0;
      Ld_Done       <= 1'b0;
      Ld_Error      <= 1'b0;
      Ld_WordCount  <= '0;
      hdr_lo        <= '0;
      csum          <= '0;
      byte_idx      <= '0;
      word_idx      <= '0;
      word_buf      <= '0;
    end else begin
      IMEM_WrEn   <= 1'b0;
      Core_rst_n  <= (state == ST_RUN);
      CPU_PCWrite <= (state == ST_RUN);
      Ld_Done     <= (state == ST_RUN);
      Ld_Error    <= (state == ST_ERROR);

      // Every accepted byte goes into the running XOR. In CSUM the comparison
      // below reads the value from before this update, which is the XOR of
      // everything ahead of the checksum byte.
      if (xfer) begin
        csum <= csum ^ Ld_Byte;
      end

      case (state)
        ST_INIT: begin
          Ld_Byte_Ready <= 1'b1;
          state         <= ST_HDR_LO;
        end

        ST_HDR_LO: begin
          if (xfer) begin
            hdr_lo <= Ld_Byte;
            state  <= ST_HDR_HI;
          end
        end

        ST_HDR_HI: begin
          if (xfer) begin
            Ld_WordCount  <= {Ld_Byte, hdr_lo};
            Ld_Byte_Ready <= 1'b0;
            state         <= ST_CHECK;
          end
        end

        // Reject images that cannot fit before any write happens. An empty
        // image goes straight to the checksum byte.
        ST_CHECK: begin
          if (Ld_WordCount > DEPTH_W) begin
            state <= ST_ERROR;
          end else if (Ld_WordCount == 16'd0) begin
            Ld_Byte_Ready <= 1'b1;
            state         <= ST_CSUM;
          end else begin
            Ld_Byte_Ready <= 1'b1;
            byte_idx      <= '0;
            word_idx      <= '0;
            state         <= ST_DATA;
          end
        end

        // Bytes 0..2 are held in word_buf. Byte 3 completes the word, which
        // goes straight to the write port, so a new word can start on the
        // very next cycle.
        ST_DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= Ld_Byte;
              2'd1: word_buf[15:8]  <= Ld_Byte;
              2'd2: word_buf[23:16] <= Ld_Byte;
              default: begin
                IMEM_WrData <= {Ld_Byte, word_buf};
                IMEM_WrAddr <= word_idx;
                IMEM_WrEn   <= 1'b1;
                word_idx    <= word_idx + 1'b1;
                if (last_hit) begin
                  state <= ST_CSUM;
                end
              end
            endcase
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            Ld_Byte_Ready <= 1'b0;
            state         <= (Ld_Byte == csum) ? ST_RELEASE : ST_ERROR;
          end
        end

        ST_RELEASE: begin
          state <= ST_RUN;
        end

        ST_RUN: begin
          Ld_Byte_Ready <= 1'b0;
        end

        ST_ERROR: begin
          Ld_Byte_Ready <= 1'b0;
        end

        default: begin
          Ld_Byte_Ready <= 1'b0;
          state         <= ST_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader. A table of directed streams is
// driven first, each with hand-written expected status. Hand-written sequences
// follow: a mid-load reset and a full 256-word image. The run ends with
// randomized streams. For every stream, the expected writes, checksum outcome
// and latency come from a behavioural model. The model works on the byte list
// directly, with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        CPU_clk;
  logic        CPU_rst;
  logic        Ld_Byte_Valid;
  logic [7:0]  Ld_Byte;
  logic        Ld_Byte_Ready;
  logic        IMEM_WrEn;
  logic [7:0]  IMEM_WrAddr;
  logic [31:0] IMEM_WrData;
  logic        Core_rst_n;
  logic        CPU_PCWrite;
  logic        Ld_Done;
  logic        Ld_Error;
  logic [15:0] Ld_WordCount;

  int pass_count;
  int check_count;

  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_words[$];
  bit          exp_ok;
  bit          exp_ovf;

  typedef struct {
    logic [95:0] data;
    int          len;
    int          max_gap;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_count;
    int          exp_writes;
  } vec_t;

  vec_t vecs[5];

  imem_boot_loader #(
    .INSTR_WIDTH(32),
    .IMEM_DEPTH (256),
    .ADDR_WIDTH (8)
  ) dut (
    .CPU_clk      (CPU_clk),
    .CPU_rst      (CPU_rst),
    .Ld_Byte_Valid(Ld_Byte_Valid),
    .Ld_Byte      (Ld_Byte),
    .Ld_Byte_Ready(Ld_Byte_Ready),
    .IMEM_WrEn    (IMEM_WrEn),
    .IMEM_WrAddr  (IMEM_WrAddr),
    .IMEM_WrData  (IMEM_WrData),
    .Core_rst_n   (Core_rst_n),
    .CPU_PCWrite  (CPU_PCWrite),
    .Ld_Done      (Ld_Done),
    .Ld_Error     (Ld_Error),
    .Ld_WordCount (Ld_WordCount)
  );

  initial CPU_clk = 1'b0;
  always #5 CPU_clk = ~CPU_clk;

  // Each write strobe is logged just after the edge that raised it. A
  // one-cycle pulse is therefore seen exactly once.
  always @(posedge CPU_clk) begin
    #1;
    if (IMEM_WrEn) begin
      got_addr.push_back(IMEM_WrAddr);
      got_data.push_back(IMEM_WrData);
    end
  end

  // Safety net in case the design stops responding altogether.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, 32'(Ld_Byte_Ready), 32'd0);
    checkOutput({tag, "_wren"},  32'(IMEM_WrEn),     32'd0);
    checkOutput({tag, "_waddr"}, 32'(IMEM_WrAddr),   32'd0);
    checkOutput({tag, "_wdata"}, IMEM_WrData,        32'd0);
    checkOutput({tag, "_crstn"}, 32'(Core_rst_n),    32'd0);
    checkOutput({tag, "_pcwr"},  32'(CPU_PCWrite),   32'd0);
    checkOutput({tag, "_done"},  32'(Ld_Done),       32'd0);
    checkOutput({tag, "_err"},   32'(Ld_Error),      32'd0);
    checkOutput({tag, "_wcnt"},  32'(Ld_WordCount),  32'd0);
  endtask

  task automatic reset_dut();
    @(negedge CPU_clk);
    CPU_rst       = 1'b1;
    Ld_Byte_Valid = 1'b0;
    Ld_Byte       = 8'h00;
    @(negedge CPU_clk);
    CPU_rst = 1'b0;
  endtask

  // Sends the first 'count' bytes of s. Before each byte there is a random
  // idle gap of 0..max_gap cycles. Returns just after the posedge that
  // accepted the last byte.
  task automatic applyStimulus(input logic [7:0] s[$], input int count,
                               input int max_gap);
    int gap;
    int waited;
    for (int i = 0; i < count; i++) begin
      gap    = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      waited = 0;
      @(negedge CPU_clk);
      if (gap > 0) begin
        Ld_Byte_Valid = 1'b0;
        repeat (gap) @(negedge CPU_clk);
      end
      Ld_Byte_Valid = 1'b1;
      Ld_Byte       = s[i];
      while (!Ld_Byte_Ready && waited < 64) begin
        @(negedge CPU_clk);
        waited++;
      end
      if (!Ld_Byte_Ready) begin
        checkOutput("ready_timeout", 32'(Ld_Byte_Ready), 32'd1);
        Ld_Byte_Valid = 1'b0;
        return;
      end
      @(posedge CPU_clk);
    end
  endtask

  // Reference model: reads the image straight from the byte list.
  task automatic model_stream(input logic [7:0] s[$]);
    int          n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_words.delete();
    n       = int'(s[0]) + 256 * int'(s[1]);
    exp_ovf = (n > 256);
    exp_ok  = 1'b0;
    if (!exp_ovf) begin
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x = x ^ s[i];
      for (int k = 0; k < n; k++) begin
        w = {s[2 + 4*k + 3], s[2 + 4*k + 2], s[2 + 4*k + 1], s[2 + 4*k]};
        exp_words.push_back(w);
      end
      exp_ok = (s[2 + 4 * n] == x);
    end
  endtask

  // Drives one complete stream, then checks status latency and the write log
  // against the model.
  task automatic run_case(input logic [7:0] s[$], input int max_gap,
                          input bit do_reset);
    int ready_seen;
    if (do_reset) reset_dut();
    got_addr.delete();
    got_data.delete();
    model_stream(s);
    if (exp_ovf) begin
      applyStimulus(s, 2, max_gap);
      #1;
      Ld_Byte_Valid = 1'b1;
      Ld_Byte       = 8'hA5;
      @(posedge CPU_clk); #1;
      checkOutput("ovf_err_early", 32'(Ld_Error), 32'd0);
      @(posedge CPU_clk); #1;
      checkOutput("ovf_err_rise", 32'(Ld_Error), 32'd1);
      ready_seen = 0;
      repeat (8) begin
        @(negedge CPU_clk);
        if (Ld_Byte_Ready) ready_seen++;
      end
      Ld_Byte_Valid = 1'b0;
      checkOutput("ovf_no_accept", 32'(ready_seen), 32'd0);
      checkOutput("ovf_done", 32'(Ld_Done), 32'd0);
      checkOutput("ovf_crstn", 32'(Core_rst_n), 32'd0);
    end else begin
      applyStimulus(s, s.size(), max_gap);
      #1;
      Ld_Byte_Valid = 1'b0;
      @(posedge CPU_clk); #1;
      checkOutput("done_early", 32'(Ld_Done), 32'd0);
      checkOutput("crstn_early", 32'(Core_rst_n), 32'd0);
      checkOutput("err_after_csum", 32'(Ld_Error), 32'(!exp_ok));
      @(posedge CPU_clk); #1;
      checkOutput("done_rise", 32'(Ld_Done), 32'(exp_ok));
      checkOutput("crstn_rise", 32'(Core_rst_n), 32'(exp_ok));
      checkOutput("pcwrite_rise", 32'(CPU_PCWrite), 32'(exp_ok));
      checkOutput("err_final", 32'(Ld_Error), 32'(!exp_ok));
      checkOutput("ready_final", 32'(Ld_Byte_Ready), 32'd0);
    end
    checkOutput("wr_count", 32'(got_addr.size()), 32'(exp_words.size()));
    for (int i = 0; i < got_addr.size() && i < exp_words.size(); i++) begin
      checkOutput($sformatf("wr_addr[%0d]", i), 32'(got_addr[i]), 32'(i));
      checkOutput($sformatf("wr_data[%0d]", i), got_data[i], exp_words[i]);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    int         n;

    pass_count    = 0;
    check_count   = 0;
    CPU_rst       = 1'b1;
    Ld_Byte_Valid = 1'b0;
    Ld_Byte       = 8'h00;

    // Directed vectors. Byte 0 is in the least significant byte of 'data'.
    vecs[0] = '{96'h92_00_10_00_93_00_00_00_13_00_02, 11, 0, 1'b1, 1'b0, 16'd2,   2};
    vecs[1] = '{96'h93_00_10_00_93_00_00_00_13_00_02, 11, 0, 1'b0, 1'b1, 16'd2,   2};
    vecs[2] = '{96'h01_01,                            2,  0, 1'b0, 1'b1, 16'd257, 0};
    vecs[3] = '{96'h00_00_00,                         3,  0, 1'b1, 1'b0, 16'd0,   0};
    vecs[4] = '{96'h92_00_10_00_93_00_00_00_13_00_02, 11, 5, 1'b1, 1'b0, 16'd2,   2};

    #2;
    check_reset_values("por");
    @(negedge CPU_clk);
    CPU_rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].len; i++) q.push_back(vecs[v].data[8*i +: 8]);
      run_case(q, vecs[v].max_gap, 1'b1);
      checkOutput($sformatf("tbl%0d_done", v), 32'(Ld_Done), 32'(vecs[v].exp_done));
      checkOutput($sformatf("tbl%0d_err", v), 32'(Ld_Error), 32'(vecs[v].exp_err));
      checkOutput($sformatf("tbl%0d_wcnt", v), 32'(Ld_WordCount), 32'(vecs[v].exp_count));
      checkOutput($sformatf("tbl%0d_writes", v), 32'(got_addr.size()), 32'(vecs[v].exp_writes));
    end

    // Reset in the middle of a load. Word 0 has just been written, so the
    // write port holds non-zero values that must clear at once.
    q.delete();
    for (int i = 0; i < vecs[0].len; i++) q.push_back(vecs[0].data[8*i +: 8]);
    reset_dut();
    applyStimulus(q, 6, 5);
    @(negedge CPU_clk);
    CPU_rst = 1'b1;
    Ld_Byte_Valid = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge CPU_clk);
    CPU_rst = 1'b0;
    run_case(q, 3, 1'b0);
    checkOutput("midrst_done", 32'(Ld_Done), 32'd1);

    // Largest image: 256 words where word k holds the value k.
    q.delete();
    q.push_back(8'h00);
    q.push_back(8'h01);
    for (int k = 0; k < 256; k++) begin
      q.push_back(8'(k));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
    run_case(q, 0, 1'b1);
    checkOutput("full_done", 32'(Ld_Done), 32'd1);
    checkOutput("full_wcnt", 32'(Ld_WordCount), 32'd256);
    if (got_addr.size() > 0) begin
      checkOutput("full_last_addr", 32'(got_addr[got_addr.size()-1]), 32'd255);
    end else begin
      checkOutput("full_last_addr", 32'(got_addr.size()), 32'd256);
    end

    // Randomized streams: a few words each, sometimes a corrupted checksum,
    // plus one stream whose header is too large.
    for (int r = 0; r < 8; r++) begin
      q.delete();
      n = (r == 7) ? 300 : int'($urandom_range(6, 0));
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      if (n <= 256) begin
        for (int b = 0; b < 4 * n; b++) q.push_back(8'($urandom));
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        if ($urandom_range(3, 0) == 0) x = x ^ 8'h5A;
        q.push_back(x);
      end
      run_case(q, int'($urandom_range(3, 0)), 1'b1);
      checkOutput($sformatf("rnd%0d_wcnt", r), 32'(Ld_WordCount), 32'(n));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder of the RV32IM single-cycle core.
- Receives a program image as a byte stream with a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction memory write port and verifies an XOR checksum.
- Holds the core in reset with PC updates disabled until a load completes cleanly, then releases it to execute from PC 0.

Parameters:
- INSTR_WIDTH, 32, instruction word width; fixed at 4 bytes per word.
- IMEM_DEPTH, 256, number of instruction words in IMEM; the maximum accepted word count.
- ADDR_WIDTH, 8, IMEM word-address width; equals clog2(IMEM_DEPTH).

Ports:
- CPU_clk  input  1  system clock, rising-edge.
- CPU_rst  input  1  asynchronous, active-high reset.
- Ld_Byte_Valid  input  1  source presents a byte.
- Ld_Byte  input  8  stream byte.
- Ld_Byte_Ready  output  1  loader accepts a byte this cycle; transfer = Valid & Ready.
- IMEM_WrEn  output  1  one-cycle IMEM write strobe.
- IMEM_WrAddr  output  ADDR_WIDTH  IMEM word address.
- IMEM_WrData  output  INSTR_WIDTH  assembled instruction word.
- Core_rst_n  output  1  active-low reset driven into the core.
- CPU_PCWrite  output  1  PC write enable into the core.
- Ld_Done  output  1  load completed; sticky until reset.
- Ld_Error  output  1  load failed; sticky until reset.
- Ld_WordCount  output  16  word count captured from the header.

Behaviour:
- Interface: one clock, CPU_clk. Reset CPU_rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: Ready 0, WrEn 0, WrAddr 0, WrData 0, Core_rst_n 0, CPU_PCWrite 0, Ld_Done 0, Ld_Error 0, Ld_WordCount 0. State = INIT.
- Stream format:
  - 2-byte header N, little-endian (low byte first).
  - N*4 data bytes, each word little-endian.
  - 1 checksum byte, equal to the XOR of all preceding bytes (header included).
- States:
  - INIT: one cycle after reset release, then HDR_LO. Ready goes to 1 on that edge.
  - HDR_LO: on transfer, capture N[7:0] and go to HDR_HI.
  - HDR_HI: on transfer, capture N[15:8], clear Ready, go to CHECK.
  - CHECK (1 cycle, Ready 0): N > IMEM_DEPTH -> ERROR. N == 0 -> CSUM. Otherwise -> DATA. Ready is set to 1 when entering DATA or CSUM.
  - DATA: a 2-bit byte index shifts each accepted byte into lane [8*idx+7:8*idx].
    - On the edge accepting byte 3: IMEM_WrData = full word, IMEM_WrAddr = word index, IMEM_WrEn = 1 for exactly one cycle; word index increments afterwards.
    - Byte acceptance continues back-to-back with no stall.
    - After word N-1 is written -> CSUM.
  - CSUM: on transfer, compare the byte with the running XOR. Match -> RELEASE. Mismatch -> ERROR. Ready drops on that edge.
  - RELEASE: one cycle; Core_rst_n is still 0.
  - RUN: Core_rst_n = 1, CPU_PCWrite = 1, Ld_Done = 1. Ready 0, terminal until reset.
  - ERROR: Ld_Error = 1, Ready 0, Core_rst_n 0, CPU_PCWrite 0. Terminal until reset.
- Latency:
  - Ld_Done, Core_rst_n and CPU_PCWrite rise exactly 2 edges after the edge accepting a matching checksum.
  - Ld_Error rises 1 edge after detection (the CHECK edge or the CSUM edge).
- Running XOR covers every accepted byte from HDR_LO onward and is cleared on reset.
- Ld_Byte and Ld_Byte_Valid are ignored while Ready = 0.
- Valid gaps: no timeout; partial word state is held indefinitely.
- Word address never wraps: N <= IMEM_DEPTH is guaranteed by CHECK, so the last address is N-1.
- Reset mid-load: immediate return to reset values and INIT. IMEM words already written are left in place, not cleared.
- Ld_WordCount updates at the HDR_HI edge and is held thereafter.

Test Plan:
- Bytes 02 00 13 00 00 00 93 00 10 00 92, continuous Valid -> WrEn pulse addr 0 data 0x00000013, pulse addr 1 data 0x00100093. Ld_WordCount = 2. Ld_Done = CPU_PCWrite = Core_rst_n = 1 two edges after checksum 0x92 accepted. Ld_Error = 0.
- Same stream with checksum 0x93 -> both writes occur, then Ld_Error = 1; Ld_Done, CPU_PCWrite, Core_rst_n stay 0; Ready stays 0.
- Header 01 01 (N = 257), IMEM_DEPTH = 256 -> Ld_Error = 1 after CHECK; zero WrEn pulses; subsequent Valid bytes are never accepted.
- Bytes 00 00 00 (N = 0) -> no WrEn pulses; Ld_Done = 1 two edges after the checksum byte.
- Test 1 stream with 0-5 random idle cycles between bytes -> identical write sequence. Then assert CPU_rst after the 6th byte -> all outputs return to reset values; a full retransmission completes with Ld_Done = 1.
- N = 256, word k = k -> 256 pulses with addresses 0..255 and data = address; last write at addr 255; Ld_Done = 1; Ld_WordCount = 256.
